// File: rtl/pwm_meter_pkg.sv
// Shared definitions for the PWM duty meter.
//   edge_state_t : edge-tracking FSM states (SEEK / TRACK / TIMEOUT)
//   DUTY_STEPS   : duty resolution (tenths)
//   DIV_ITER     : restoring-divider iterations (quotient bits)
package pwm_meter_pkg;

    typedef enum logic [1:0] {
        SEEK    = 2'd0,
        TRACK   = 2'd1,
        TIMEOUT = 2'd2
    } edge_state_t;

    localparam int unsigned DUTY_STEPS = 10;
    localparam int unsigned DIV_ITER   = 4;

endpackage

// File: rtl/pwm_duty_div.sv
// Start/busy/done restoring divider producing
//   quot = (DUTY_STEPS*high_time + period/2) / period.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : latch operands and begin; restarts (aborts) any division in flight
//   high_time : H operand, sampled on start
//   period    : P operand, sampled on start
//   done      : high during the final iteration cycle, quot valid with it
//   quot      : 4-bit quotient (0..10 since H < P)
module pwm_duty_div
    import pwm_meter_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] high_time,
    input  logic [CNT_W-1:0] period,
    output logic             done,
    output logic [3:0]       quot
);

    localparam int unsigned NW = CNT_W + 4;
    localparam int unsigned IW = $clog2(DIV_ITER);

    logic [NW-1:0]       rem_q;
    logic [NW-1:0]       den_q;
    logic [DIV_ITER-1:0] q_q;
    logic [IW-1:0]       iter_q;
    logic                busy;
    logic                ge;
    logic                last;
    logic [NW-1:0]       num;
    logic [NW-1:0]       den0;

    assign num  = NW'(high_time) * NW'(DUTY_STEPS) + NW'(period >> 1);
    // Divisor starts aligned to the quotient MSB and walks down one bit per cycle.
    assign den0 = NW'(period) << (DIV_ITER - 1);
    assign ge   = (rem_q >= den_q);
    assign last = (iter_q == IW'(DIV_ITER - 1));

    // A simultaneous restart suppresses the result of the old operands.
    assign done = busy && last && !start;
    assign quot = {q_q[DIV_ITER-2:0], ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            iter_q <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            q_q    <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            iter_q <= '0;
            rem_q  <= num;
            den_q  <= den0;
            q_q    <= '0;
        end else if (busy) begin
            if (ge) begin
                rem_q <= rem_q - den_q;
            end
            den_q  <= den_q >> 1;
            q_q    <= {q_q[DIV_ITER-2:0], ge};
            iter_q <= iter_q + 1'b1;
            if (last) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pwm_duty_meter.sv
// PWM duty meter: measures period and high time of an asynchronous PWM input
// in clock cycles and reports the rounded duty in tenths.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   pwm_in      : asynchronous PWM input
//   period      : clocks between the last two rising edges
//   high_time   : clocks from rising to falling edge within that period
//   duty_tenths : rounded duty 0..10
//   meas_valid  : one-cycle strobe, outputs updated in the same cycle
//   no_signal   : set on timeout, cleared by the next rising edge
// Build option: PWM_METER_GLITCH_FILTER_EN enables a 3-sample glitch filter.
module pwm_duty_meter
    import pwm_meter_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [3:0]       duty_tenths,
    output logic             meas_valid,
    output logic             no_signal
);

    logic             sync1;
    logic             sync2;
    logic             s;
    logic             s_d;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hreg;
    logic [CNT_W-1:0] p_cap;
    logic [CNT_W-1:0] h_cap;
    logic             cnt_max;
    logic             capture;
    logic             to_timeout;
    logic             div_done;
    logic [3:0]       div_quot;
    edge_state_t      state_q;
    edge_state_t      state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
        end
    end

`ifdef PWM_METER_GLITCH_FILTER_EN
    logic sync3;
    logic s_q;

    // s follows only after three equal consecutive synchronized samples;
    // both edges see the same extra delay, so P and H are unaffected.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync3 <= 1'b0;
            s_q   <= 1'b0;
        end else begin
            sync3 <= sync2;
            if (sync1 == sync2 && sync2 == sync3) begin
                s_q <= sync1;
            end
        end
    end

    assign s = s_q;
`else
    assign s = sync2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s_d <= 1'b0;
        end else begin
            s_d <= s;
        end
    end

    assign rise    = s & ~s_d;
    assign fall    = ~s & s_d;
    assign cnt_max = (cnt == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            hreg <= '0;
        end else begin
            if (rise) begin
                cnt <= CNT_W'(1);
            end else if (!cnt_max) begin
                cnt <= cnt + 1'b1;
            end
            if (fall) begin
                hreg <= cnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEEK;
        end else begin
            state_q <= state_d;
        end
    end

    // Saturation wins over a coincident rise: that period is not measurable.
    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        to_timeout = 1'b0;
        case (state_q)
            SEEK: begin
                if (rise) begin
                    state_d = TRACK;
                end
            end
            TRACK: begin
                if (cnt_max) begin
                    state_d    = TIMEOUT;
                    to_timeout = 1'b1;
                end else if (rise) begin
                    capture = 1'b1;
                end
            end
            TIMEOUT: begin
                if (rise) begin
                    state_d = TRACK;
                end
            end
            default: begin
                state_d = SEEK;
            end
        endcase
    end

    // P/H held alongside the division so they are published with its quotient.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_cap <= '0;
            h_cap <= '0;
        end else if (capture) begin
            p_cap <= cnt;
            h_cap <= hreg;
        end
    end

    pwm_duty_div #(
        .CNT_W(CNT_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (capture),
        .high_time(hreg),
        .period   (cnt),
        .done     (div_done),
        .quot     (div_quot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            period      <= '0;
            high_time   <= '0;
            duty_tenths <= '0;
            meas_valid  <= 1'b0;
            no_signal   <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (to_timeout) begin
                meas_valid  <= 1'b1;
                period      <= '0;
                high_time   <= '0;
                duty_tenths <= s ? 4'(DUTY_STEPS) : 4'd0;
                no_signal   <= 1'b1;
            end else if (div_done) begin
                meas_valid  <= 1'b1;
                period      <= p_cap;
                high_time   <= h_cap;
                duty_tenths <= div_quot;
            end
            if (state_q == TIMEOUT && rise) begin
                no_signal <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Scoreboard bench for pwm_duty_meter (CNT_W=8 so timeouts are reachable).
// The driver keeps a waveform-level model: each effective rising edge of the
// driven PWM yields P (time since previous rise) and H (previous high phase),
// and the expected strobe is queued; a monitor pops on meas_valid.
`timescale 1ns/1ps
module tb_pwm_duty_meter;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned TMAX  = (1 << CNT_W) - 1;
    // Driven edge -> strobe visible, in clocks (sync + detect + divide + register).
    localparam int unsigned LAT   = 7;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pwm_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic [3:0]       duty_tenths;
    logic             meas_valid;
    logic             no_signal;

    pwm_duty_meter #(
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .period     (period),
        .high_time  (high_time),
        .duty_tenths(duty_tenths),
        .meas_valid (meas_valid),
        .no_signal  (no_signal)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned p;
        int unsigned h;
        int unsigned d;
        bit          ns;
        int unsigned ts;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    // waveform model state
    bit          hist0 = 1'b0, hist1 = 1'b0, hist2 = 1'b0;
    bit          e = 1'b0;
    bit          have_ref = 1'b0;
    int unsigned last_rise = 0;
    int unsigned last_fall = 0;

    task automatic push_exp(input int unsigned p, input int unsigned h,
                            input int unsigned d, input bit ns, input int unsigned ts);
        exp_t x;
        x.p = p; x.h = h; x.d = d; x.ns = ns; x.ts = ts;
        sb.push_back(x);
    endtask

    task automatic model_update(input bit b, input int unsigned t);
        bit ne;
`ifdef PWM_METER_GLITCH_FILTER_EN
        hist2 = hist1; hist1 = hist0; hist0 = b;
        ne = e;
        if (hist0 == hist1 && hist1 == hist2) ne = hist0;
`else
        ne = b;
`endif
        if (ne && !e) begin
            if (have_ref) begin
                int unsigned p, h;
                p = t - last_rise;
                h = last_fall - last_rise;
                push_exp(p, h, (10 * h + p / 2) / p, 1'b0, t + LAT);
            end
            have_ref  = 1'b1;
            last_rise = t;
        end else if (!ne && e) begin
            last_fall = t;
        end else if (have_ref && (t - last_rise) == TMAX) begin
            push_exp(0, 0, e ? 10 : 0, 1'b1, t + 3);
            have_ref = 1'b0;
        end
        e = ne;
    endtask

    task automatic step(input bit b, input bit r);
        @(posedge clk);
        #1;
        pwm_in = b;
        rst    = r;
        if (r) begin
            hist0 = 1'b0; hist1 = 1'b0; hist2 = 1'b0;
            e = 1'b0;
            have_ref = 1'b0;
            // anything not yet strobed by the reset-sampling edge is discarded
            while (sb.size() > 0 && sb[sb.size()-1].ts >= cyc + 1) void'(sb.pop_back());
        end else begin
            model_update(b, cyc);
        end
    endtask

    task automatic drive(input bit b, input int unsigned n);
        repeat (n) step(b, 1'b0);
    endtask

    task automatic pulse(input int unsigned h, input int unsigned l);
        drive(1'b1, h);
        drive(1'b0, l);
    endtask

    // monitor
    bit               prev_rst = 1'b1;
    logic [CNT_W-1:0] hp = '0;
    logic [CNT_W-1:0] hh = '0;
    logic [3:0]       hd = '0;
    exp_t             mx;

    always @(negedge clk) begin
        if (prev_rst) begin
            checks++;
            if (period === '0 && high_time === '0 && duty_tenths === '0 &&
                meas_valid === 1'b0 && no_signal === 1'b0)
                passed++;
            else
                $display("FAIL reset_state @%0d: period=%0d high=%0d duty=%0d valid=%b no_signal=%b, expected all 0",
                         cyc, period, high_time, duty_tenths, meas_valid, no_signal);
            hp = '0; hh = '0; hd = '0;
        end else if (meas_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_strobe @%0d: period=%0d high=%0d duty=%0d, expected no strobe",
                         cyc, period, high_time, duty_tenths);
            end else begin
                mx = sb.pop_front();
                if (period === CNT_W'(mx.p) && high_time === CNT_W'(mx.h) &&
                    duty_tenths === 4'(mx.d) && no_signal === mx.ns && cyc == mx.ts)
                    passed++;
                else
                    $display("FAIL strobe @%0d: period=%0d high=%0d duty=%0d no_signal=%b; expected period=%0d high=%0d duty=%0d no_signal=%b @%0d",
                             cyc, period, high_time, duty_tenths, no_signal,
                             mx.p, mx.h, mx.d, mx.ns, mx.ts);
                hp = CNT_W'(mx.p); hh = CNT_W'(mx.h); hd = 4'(mx.d);
            end
        end else begin
            if (sb.size() > 0 && cyc > sb[0].ts) begin
                checks++;
                $display("FAIL missed_strobe @%0d: no meas_valid, expected period=%0d high=%0d duty=%0d @%0d",
                         cyc, sb[0].p, sb[0].h, sb[0].d, sb[0].ts);
                void'(sb.pop_front());
            end
            checks++;
            if (period === hp && high_time === hh && duty_tenths === hd)
                passed++;
            else
                $display("FAIL hold @%0d: period=%0d high=%0d duty=%0d, expected %0d %0d %0d",
                         cyc, period, high_time, duty_tenths, hp, hh, hd);
        end
        prev_rst = rst;
    end

    initial begin
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        drive(1'b0, 5);

        // steady P=10 H=5
        repeat (8) pulse(5, 5);
        // duty step to H=9 at P=10
        repeat (5) pulse(9, 1);
        // rounding cases
        repeat (3) pulse(7, 13);
        repeat (3) pulse(5, 15);

        // 1-cycle glitch in the low phase at P=20 H=10
        repeat (2) pulse(10, 10);
        drive(1'b1, 10);
        drive(1'b0, 4);
        drive(1'b1, 1);
        drive(1'b0, 5);
        repeat (3) pulse(10, 10);

        // randomized periods
        repeat (25) pulse($urandom_range(3, 25), $urandom_range(3, 25));

        // reset shortly after a rise: in-flight result discarded
        repeat (3) pulse(6, 6);
        drive(1'b1, 3);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        drive(1'b1, 4);
        drive(1'b0, 6);
        repeat (4) pulse(6, 6);

        // line stuck high -> timeout, then recovery
        repeat (2) pulse(5, 5);
        drive(1'b1, TMAX + 20);
        drive(1'b0, 5);
        repeat (3) pulse(5, 5);

        // line stuck low -> timeout with duty 0, then recovery
        drive(1'b1, 5);
        drive(1'b0, TMAX + 20);
        repeat (3) pulse(4, 4);

        drive(1'b0, 40);

        checks++;
        if (sb.size() == 0)
            passed++;
        else
            $display("FAIL pending_at_end: %0d expected strobes never seen, required 0", sb.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
